// File: rtl/conv_pkg.sv
// Shared types, dimensions and flat-bus index helpers for the 3x3-over-4x4
// convolution sequencer.
package conv_pkg;

   localparam int DATA_DIM = 4;
   localparam int FILT_DIM = 3;
   localparam int OUT_DIM  = 2;
   localparam int PIX_W    = 8;
   localparam int ACC_W    = 20;

   localparam int DATA_W   = DATA_DIM * DATA_DIM * PIX_W;
   localparam int FILT_W   = FILT_DIM * FILT_DIM * PIX_W;
   localparam int RES_W    = OUT_DIM * OUT_DIM * PIX_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MAC   = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Filter row for tap index k = 3i + j.
   function automatic logic [1:0] tap_row(input logic [3:0] k);
      logic [1:0] r;
      case (k)
         4'd0, 4'd1, 4'd2: r = 2'd0;
         4'd3, 4'd4, 4'd5: r = 2'd1;
         default:          r = 2'd2;
      endcase
      return r;
   endfunction

   // Filter column for tap index k = 3i + j.
   function automatic logic [1:0] tap_col(input logic [3:0] k);
      return 2'(k % 4'd3);
   endfunction

   // Bit offset of data pixel (r,c): 8*(4r+c).
   function automatic logic [6:0] data_off(input logic [1:0] r, input logic [1:0] c);
      return {r, c, 3'b000};
   endfunction

   // Bit offset of filter tap (i,j): 8*(3i+j).
   function automatic logic [6:0] filt_off(input logic [1:0] i, input logic [1:0] j);
      return 7'((3 * i + j) * 8);
   endfunction

   // Bit offset of result pixel for output position pos = 2r+c.
   function automatic logic [4:0] res_off(input logic [1:0] pos);
      return {pos, 3'b000};
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Shared multiply-accumulate unit with a 20-bit accumulator and a
// combinational shift + 8-bit saturation view of the running sum.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        clear accumulator (wins over en)
//   en         accumulate a*b this cycle
//   a, b       unsigned 8-bit operands
//   sat_o      sat8(acc >> SHIFT)
module conv_mac
   import conv_pkg::*;
#(
   parameter int SHIFT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [PIX_W-1:0] a,
   input  logic [PIX_W-1:0] b,
   output logic [PIX_W-1:0] sat_o
);

   logic [ACC_W-1:0]   acc_q;
   logic [2*PIX_W-1:0] prod;
   logic [ACC_W-1:0]   shifted;

   assign prod = (2*PIX_W)'(a) * (2*PIX_W)'(b);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= acc_q + ACC_W'(prod);
      end
   end

   assign shifted = acc_q >> SHIFT;
   assign sat_o   = (shifted > ACC_W'(255)) ? 8'hFF : shifted[PIX_W-1:0];

endmodule

// File: rtl/conv_sequencer.sv
// Sequences a 3x3 convolution over a 4x4 tile into a 2x2 result, one MAC
// per cycle through a single shared conv_mac.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle run request (ignored unless idle)
//   mem_ready     memory contents valid; LOAD waits on it
//   data_in       4x4 pixels, (r,c) at [8*(4r+c)+:8]
//   filter_in     3x3 taps,   (i,j) at [8*(3i+j)+:8]
//   busy          high in every state but IDLE
//   done          one-cycle completion pulse
//   result_valid  result holds a finished tile
//   result        2x2 outputs, (r,c) at [8*(2r+c)+:8]
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | waiting for mem_ready, then snapshot buses
// MAC   | one tap per cycle for current output position
// STORE | write saturated sum of current position
// DONE  | completion pulse, back to IDLE
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int SHIFT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [FILT_W-1:0] filter_in,
   output logic              busy,
   output logic              done,
   output logic              result_valid,
   output logic [RES_W-1:0]  result
);

   state_t            state_q;
   logic              busy_q, done_q, valid_q;
   logic [RES_W-1:0]  result_q;
   logic [DATA_W-1:0] data_q;
   logic [FILT_W-1:0] filt_q;
   logic [1:0]        pos_q;
   logic [3:0]        k_q;

   logic [1:0]        ti, tj, dr, dc;
   logic [PIX_W-1:0]  mac_a, mac_b, mac_sat;
   logic              mac_en, mac_clr;

   // Operand select: output position supplies the window origin, tap index
   // supplies the offset inside it.
   assign ti    = tap_row(k_q);
   assign tj    = tap_col(k_q);
   assign dr    = {1'b0, pos_q[1]} + ti;
   assign dc    = {1'b0, pos_q[0]} + tj;
   assign mac_a = data_q[data_off(dr, dc) +: PIX_W];
   assign mac_b = filt_q[filt_off(ti, tj) +: PIX_W];

   assign mac_en  = (state_q == MAC);
   assign mac_clr = ((state_q == LOAD) && mem_ready) || (state_q == STORE);

   conv_mac #(.SHIFT(SHIFT)) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .sat_o (mac_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
         data_q   <= '0;
         filt_q   <= '0;
         pos_q    <= '0;
         k_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= LOAD;
                  busy_q   <= 1'b1;
                  result_q <= '0;
                  valid_q  <= 1'b0;
               end
            end
            LOAD: begin
               if (mem_ready) begin
                  data_q  <= data_in;
                  filt_q  <= filter_in;
                  pos_q   <= '0;
                  k_q     <= '0;
                  state_q <= MAC;
               end
            end
            MAC: begin
               if (k_q == 4'd8) begin
                  state_q <= STORE;
               end else begin
                  k_q <= k_q + 4'd1;
               end
            end
            STORE: begin
               result_q[res_off(pos_q) +: PIX_W] <= mac_sat;
               k_q <= '0;
               if (pos_q == 2'd3) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  valid_q <= 1'b1;
               end else begin
                  pos_q   <= pos_q + 2'd1;
                  state_q <= MAC;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = valid_q;
   assign result       = result_q;

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Controller that sequences the 3x3 convolution over the 4x4 data tile held in memory, producing the 2x2 result tile.
- Waits for memory-loaded status, snapshots the DATA/FILTER buses, then walks the 4 output positions × 9 taps with one multiply-accumulate per cycle through a single shared MAC.
- Returns the packed 32-bit result and a completion pulse to the memory side.

Parameters:
- SHIFT, 8, right shift applied to each 20-bit accumulator before 8-bit saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle request to run one convolution.
- mem_ready  in  1  high when memory holds valid data/filter (init complete).
- data_in  in  128  data (r,c), r,c in 0..3, at [8*(4r+c)+:8], unsigned.
- filter_in  in  72  filter (i,j), i,j in 0..2, at [8*(3i+j)+:8], unsigned.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when result is complete.
- result_valid  out  1  high from done until the next accepted start.
- result  out  32  output (r,c), r,c in 0..1, at [8*(2r+c)+:8].

Behaviour:
- Reset (sync, clk edge with rst=1): state IDLE; busy=0, done=0, result_valid=0, result=0; accumulator, tap index and position cleared. Applies mid-operation: the run is abandoned and no done is issued.
- FSM states: IDLE, LOAD, MAC, STORE, DONE.
  - IDLE: start=1 → LOAD. On acceptance, result=0 and result_valid=0.
  - LOAD: holds while mem_ready=0, no timeout. When mem_ready=1, latch data_in/filter_in into internal snapshot registers, clear acc, pos=0, k=0 → MAC. Bus changes after this latch do not affect the run.
  - MAC: each cycle acc += D(or+i, oc+j) * F(i,j), where k=3i+j, or=pos[1], oc=pos[0]. k increments 0..8; the cycle with k=8 → STORE.
  - STORE: result[8*pos+:8] = sat8(acc >> SHIFT), where sat8 yields 255 if the value exceeds 255. Clear acc and k. If pos==3 → DONE, else pos++ → MAC.
  - DONE: done=1 for exactly this cycle; result_valid set → IDLE.
- Widths:
  - product 16 bits.
  - acc 20 bits; maximum 9·255·255 = 585225, so acc never overflows.
  - Shift is logical.
- Latency, with mem_ready already high: start sampled at edge 0, LOAD at 1, MAC 2–10, STORE 11; each position takes 10 cycles; final STORE at 41; done high in the cycle after edge 42. Each cycle mem_ready is low in LOAD adds one cycle.
- start while busy: ignored, no queuing. start in the DONE cycle: ignored.
- done and busy are Moore outputs (registered state decode).
- result is stable and readable whenever result_valid=1.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE, LOAD, MAC, STORE, DONE);
  - constants DATA_DIM=4, FILT_DIM=3, OUT_DIM=2, PIX_W=8, ACC_W=20;
  - index helper functions for the flat-bus byte offsets.
- One sub-module, conv_mac: inputs 8b a, 8b b, clr, en; holds the 20b accumulator; combinational sat8/shift output. The FSM, operand muxing and result register stay in conv_sequencer.

Test Plan:
- SHIFT=0, all data=1, all filter=1, mem_ready=1, pulse start → done 42 cycles later, result=0x09090909, result_valid=1, busy low afterwards.
- SHIFT=0, data(r,c)=4r+c, filter center=1 and others 0 → result=0x0A090605 (bytes 5,6,9,10).
- SHIFT=8, all data=255, all filter=255 → acc=585225, shifted 2286, saturated; result=0xFFFFFFFF.
- mem_ready held low 5 cycles after start, then high → busy stays high in LOAD, done at cycle 47. Change data_in to all-0 after the LOAD latch → result unchanged from the latched values.
- Second start pulse at cycle 10 of a run → ignored; exactly one done pulse. New start after done clears result_valid and result on acceptance.
- Assert rst for 1 cycle at cycle 20 of a run → next cycle busy=0, result=0, no done. A fresh start then completes normally with the correct result.
